// File: rtl/unidade_controle_prova_if.sv
// Control/status bundle between the game controller and its datapath.
// master = controller side, slave = datapath / top-level side.
interface unidade_controle_prova_if;
   logic       iniciar;
   logic       fez_jogada;
   logic       jogada_igual_memoria;
   logic       endereco_igual_limite;
   logic       ultimo_nivel;
   logic       deu_timeout;
   logic       zera_contador_nivel;
   logic       zera_contador_jogada;
   logic       zera_contador_score;
   logic       conta_nivel;
   logic       conta_jogada;
   logic       conta_score;
   logic       zeraR;
   logic       registraR;
   logic       zera_timeout;
   logic       conta_timeout;
   logic       pronto;
   logic       ganhou;
   logic       perdeu;
   logic       timeout;
   logic [3:0] db_estado;

   modport master (
      input  iniciar, fez_jogada,
      input  jogada_igual_memoria,
      input  endereco_igual_limite,
      input  ultimo_nivel, deu_timeout,
      output zera_contador_nivel,
      output zera_contador_jogada,
      output zera_contador_score,
      output conta_nivel, conta_jogada,
      output conta_score,
      output zeraR, registraR,
      output zera_timeout, conta_timeout,
      output pronto, ganhou, perdeu,
      output timeout, db_estado
   );

   modport slave (
      output iniciar, fez_jogada,
      output jogada_igual_memoria,
      output endereco_igual_limite,
      output ultimo_nivel, deu_timeout,
      input  zera_contador_nivel,
      input  zera_contador_jogada,
      input  zera_contador_score,
      input  conta_nivel, conta_jogada,
      input  conta_score,
      input  zeraR, registraR,
      input  zera_timeout, conta_timeout,
      input  pronto, ganhou, perdeu,
      input  timeout, db_estado
   );
endinterface

// File: rtl/unidade_controle_prova.sv
// Moore controller for the Genius-style game datapath.
// Outputs are registered from the next state, so they track db_estado.
module unidade_controle_prova #(
   parameter bit TIMEOUT_ATIVO = 1'b1
) (
   input  logic clock,
   input  logic reset,
   unidade_controle_prova_if.master bus
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      INICIO_NIVEL   = 4'h2,
      ESPERA_JOGADA  = 4'h3,
      REGISTRA       = 4'h4,
      COMPARACAO     = 4'h5,
      PROXIMA_JOGADA = 4'h6,
      ULTIMA_JOGADA  = 4'h7,
      PROXIMO_NIVEL  = 4'h8,
      FIM_ACERTOU    = 4'hA,
      FIM_TIMEOUT    = 4'hD,
      FIM_ERROU      = 4'hE
   } estado_t;

   typedef struct packed {
      logic zcn;
      logic zcj;
      logic zcs;
      logic cn;
      logic cj;
      logic cs;
      logic zr;
      logic rr;
      logic zt;
      logic ct;
      logic pronto;
      logic ganhou;
      logic perdeu;
      logic timeout;
   } saidas_t;

   logic [3:0] estado_q, estado_d;
   saidas_t    saidas_q;

   function automatic saidas_t decodifica(
      input logic [3:0] e
   );
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO: begin
            s.zcn = 1'b1;
            s.zcj = 1'b1;
            s.zcs = 1'b1;
            s.zr  = 1'b1;
            s.zt  = 1'b1;
         end
         INICIO_NIVEL: begin
            s.zcj = 1'b1;
            s.zr  = 1'b1;
            s.zt  = 1'b1;
         end
         ESPERA_JOGADA:  s.ct = 1'b1;
         REGISTRA: begin
            s.rr = 1'b1;
            s.zt = 1'b1;
         end
         PROXIMA_JOGADA: s.cj = 1'b1;
         ULTIMA_JOGADA:  s.cs = 1'b1;
         PROXIMO_NIVEL:  s.cn = 1'b1;
         FIM_ACERTOU: begin
            s.pronto = 1'b1;
            s.ganhou = 1'b1;
         end
         FIM_ERROU: begin
            s.pronto = 1'b1;
            s.perdeu = 1'b1;
         end
         FIM_TIMEOUT: begin
            s.pronto  = 1'b1;
            s.timeout = 1'b1;
         end
         default: s = '0;
      endcase
      return s;
   endfunction

   // A press beats a simultaneous timeout in espera_jogada.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:
            if (bus.iniciar) estado_d = PREPARACAO;
         PREPARACAO:     estado_d = INICIO_NIVEL;
         INICIO_NIVEL:   estado_d = ESPERA_JOGADA;
         ESPERA_JOGADA:
            if (bus.fez_jogada)
               estado_d = REGISTRA;
            else if (bus.deu_timeout && TIMEOUT_ATIVO)
               estado_d = FIM_TIMEOUT;
         REGISTRA:       estado_d = COMPARACAO;
         COMPARACAO:
            if (!bus.jogada_igual_memoria)
               estado_d = FIM_ERROU;
            else if (bus.endereco_igual_limite)
               estado_d = ULTIMA_JOGADA;
            else
               estado_d = PROXIMA_JOGADA;
         PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
         ULTIMA_JOGADA:
            if (bus.ultimo_nivel)
               estado_d = FIM_ACERTOU;
            else
               estado_d = PROXIMO_NIVEL;
         PROXIMO_NIVEL:  estado_d = INICIO_NIVEL;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
            if (bus.iniciar) estado_d = PREPARACAO;
         default:        estado_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIAL;
         saidas_q <= '0;
      end else begin
         estado_q <= estado_d;
         saidas_q <= decodifica(estado_d);
      end
   end

   assign bus.zera_contador_nivel  = saidas_q.zcn;
   assign bus.zera_contador_jogada = saidas_q.zcj;
   assign bus.zera_contador_score  = saidas_q.zcs;
   assign bus.conta_nivel          = saidas_q.cn;
   assign bus.conta_jogada         = saidas_q.cj;
   assign bus.conta_score          = saidas_q.cs;
   assign bus.zeraR                = saidas_q.zr;
   assign bus.registraR            = saidas_q.rr;
   assign bus.zera_timeout         = saidas_q.zt;
   assign bus.conta_timeout        = saidas_q.ct;
   assign bus.pronto               = saidas_q.pronto;
   assign bus.ganhou               = saidas_q.ganhou;
   assign bus.perdeu               = saidas_q.perdeu;
   assign bus.timeout              = saidas_q.timeout;
   assign bus.db_estado            = estado_q;

endmodule

// File: tb/tb_unidade_controle_prova.sv
// Directed bench for unidade_controle_prova.
// A second instance runs with the timeout disabled.
module tb_unidade_controle_prova;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clock = ~clock;

   unidade_controle_prova_if bus ();
   unidade_controle_prova_if bus_p ();

   unidade_controle_prova #(
      .TIMEOUT_ATIVO(1'b1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   unidade_controle_prova #(
      .TIMEOUT_ATIVO(1'b0)
   ) dut_p (
      .clock(clock),
      .reset(reset),
      .bus  (bus_p.master)
   );

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs;
      bus.iniciar                 = 1'b0;
      bus.fez_jogada              = 1'b0;
      bus.jogada_igual_memoria    = 1'b0;
      bus.endereco_igual_limite   = 1'b0;
      bus.ultimo_nivel            = 1'b0;
      bus.deu_timeout             = 1'b0;
      bus_p.iniciar               = 1'b0;
      bus_p.fez_jogada            = 1'b0;
      bus_p.jogada_igual_memoria  = 1'b0;
      bus_p.endereco_igual_limite = 1'b0;
      bus_p.ultimo_nivel          = 1'b0;
      bus_p.deu_timeout           = 1'b0;
   endtask

   // Leaves both instances in espera_jogada.
   task automatic start_match;
      clear_inputs();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      bus.iniciar   = 1'b1;
      bus_p.iniciar = 1'b1;
      step();
      bus.iniciar   = 1'b0;
      bus_p.iniciar = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset;
      start_match();
      n_checks++;
      if (bus.conta_timeout !== 1'b1)
         $display("FAIL rst_pre_ct: got %0b want 1",
                  bus.conta_timeout);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.db_estado !== 4'h0)
         $display("FAIL rst_state: got %0h want 0",
                  bus.db_estado);
      else n_pass++;
      n_checks++;
      if (bus.conta_timeout !== 1'b0)
         $display("FAIL rst_ct: got %0b want 0",
                  bus.conta_timeout);
      else n_pass++;
      reset = 1'b0;
      bus.iniciar = 1'b1;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h1 ||
          bus.zera_contador_nivel !== 1'b1)
         $display("FAIL prep: got st %0h zcn %0b want 1 1",
                  bus.db_estado, bus.zera_contador_nivel);
      else n_pass++;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h2 ||
          bus.zera_contador_nivel !== 1'b0)
         $display("FAIL ini_nivel: got st %0h zcn %0b want 2 0",
                  bus.db_estado, bus.zera_contador_nivel);
      else n_pass++;
      bus.iniciar = 1'b0;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h3 ||
          bus.zera_contador_nivel !== 1'b0)
         $display("FAIL espera: got st %0h zcn %0b want 3 0",
                  bus.db_estado, bus.zera_contador_nivel);
      else n_pass++;
   endtask

   task automatic test_level0;
      logic [3:0] seq [6] = '{4'h4, 4'h5, 4'h7,
                              4'h8, 4'h2, 4'h3};
      int cs = 0;
      int cn = 0;
      start_match();
      bus.fez_jogada            = 1'b1;
      bus.jogada_igual_memoria  = 1'b1;
      bus.endereco_igual_limite = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         bus.fez_jogada = 1'b0;
         cs += int'(bus.conta_score);
         cn += int'(bus.conta_nivel);
         n_checks++;
         if (bus.db_estado !== seq[i])
            $display("FAIL lvl0_seq%0d: got %0h want %0h",
                     i, bus.db_estado, seq[i]);
         else n_pass++;
      end
      n_checks++;
      if (cs != 1 || cn != 1)
         $display("FAIL lvl0_pulses: got cs %0d cn %0d want 1 1",
                  cs, cn);
      else n_pass++;
   endtask

   task automatic test_level2;
      int cj = 0;
      start_match();
      bus.jogada_igual_memoria = 1'b1;
      for (int p = 0; p < 3; p++) begin
         bus.endereco_igual_limite = (p == 2);
         bus.fez_jogada = 1'b1;
         step();
         bus.fez_jogada = 1'b0;
         n_checks++;
         if (bus.db_estado !== 4'h4 ||
             bus.zera_timeout !== 1'b1)
            $display("FAIL lvl2_reg%0d: got st %0h zt %0b want 4 1",
                     p, bus.db_estado, bus.zera_timeout);
         else n_pass++;
         step();
         if (p < 2) begin
            step();
            cj += int'(bus.conta_jogada);
            step();
            n_checks++;
            if (bus.db_estado !== 4'h3)
               $display("FAIL lvl2_back%0d: got %0h want 3",
                        p, bus.db_estado);
            else n_pass++;
         end
      end
      step();
      n_checks++;
      if (bus.db_estado !== 4'h7 || cj != 2)
         $display("FAIL lvl2_end: got st %0h cj %0d want 7 2",
                  bus.db_estado, cj);
      else n_pass++;
   endtask

   task automatic test_wrong;
      start_match();
      bus.fez_jogada = 1'b1;
      step();
      bus.fez_jogada = 1'b0;
      step();
      step();
      n_checks++;
      if (bus.db_estado !== 4'hE || bus.pronto !== 1'b1 ||
          bus.perdeu !== 1'b1 || bus.ganhou !== 1'b0)
         $display("FAIL errou: got st %0h p%0b l%0b w%0b want E 1 1 0",
                  bus.db_estado, bus.pronto, bus.perdeu,
                  bus.ganhou);
      else n_pass++;
      step();
      step();
      n_checks++;
      if (bus.db_estado !== 4'hE)
         $display("FAIL errou_hold: got %0h want E",
                  bus.db_estado);
      else n_pass++;
      bus.iniciar = 1'b1;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h1)
         $display("FAIL restart: got %0h want 1",
                  bus.db_estado);
      else n_pass++;
      step();
      step();
      step();
      n_checks++;
      if (bus.db_estado !== 4'h3)
         $display("FAIL iniciar_ign: got %0h want 3",
                  bus.db_estado);
      else n_pass++;
      bus.iniciar = 1'b0;
   endtask

   task automatic test_timeout;
      start_match();
      bus.deu_timeout   = 1'b1;
      bus_p.deu_timeout = 1'b1;
      step();
      step();
      n_checks++;
      if (bus.db_estado !== 4'hD || bus.timeout !== 1'b1 ||
          bus.pronto !== 1'b1)
         $display("FAIL tmo: got st %0h t%0b p%0b want D 1 1",
                  bus.db_estado, bus.timeout, bus.pronto);
      else n_pass++;
      n_checks++;
      if (bus_p.db_estado !== 4'h3 || bus_p.timeout !== 1'b0)
         $display("FAIL tmo_pratica: got st %0h t%0b want 3 0",
                  bus_p.db_estado, bus_p.timeout);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      start_match();
      bus.fez_jogada  = 1'b1;
      bus.deu_timeout = 1'b1;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h4)
         $display("FAIL press_vs_tmo: got %0h want 4",
                  bus.db_estado);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_final_level;
      logic [3:0] seq [4] = '{4'h4, 4'h5, 4'h7, 4'hA};
      int cn = 0;
      start_match();
      bus.fez_jogada            = 1'b1;
      bus.jogada_igual_memoria  = 1'b1;
      bus.endereco_igual_limite = 1'b1;
      bus.ultimo_nivel          = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         bus.fez_jogada = 1'b0;
         cn += int'(bus.conta_nivel);
         n_checks++;
         if (bus.db_estado !== seq[i])
            $display("FAIL final_seq%0d: got %0h want %0h",
                     i, bus.db_estado, seq[i]);
         else n_pass++;
      end
      n_checks++;
      if (cn != 0 || bus.ganhou !== 1'b1 ||
          bus.pronto !== 1'b1)
         $display("FAIL ganhou: got cn %0d w%0b p%0b want 0 1 1",
                  cn, bus.ganhou, bus.pronto);
      else n_pass++;
      @(negedge clock);
      force dut.estado_q = 4'hB;
      #1;
      release dut.estado_q;
      step();
      n_checks++;
      if (bus.db_estado !== 4'h0)
         $display("FAIL unused_code: got %0h want 0",
                  bus.db_estado);
      else n_pass++;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_level0();
      test_level2();
      test_wrong();
      test_timeout();
      test_back_to_back();
      test_final_level();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/unidade_controle_prova.md
Name: unidade_controle_prova

Overview:
- Moore FSM that sequences fluxo_de_dados_prova, the Genius-style game datapath.
- Per match it clears the counters. It then walks the play counter through the current level, waits for button presses under timeout, and registers and compares each play.
- On a correct level it advances level and score. The match ends on win, wrong play or timeout.
- Sits between the top-level game module and the datapath. It drives every datapath control input and consumes its status outputs.

Parameters:
- TIMEOUT_ATIVO, 1, 1 = deu_timeout ends the match; 0 = deu_timeout ignored (practice mode).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state inicial
- iniciar  input  1  start/restart request, level-sensitive
- fez_jogada  input  1  one-cycle press pulse from datapath edge detector
- jogada_igual_memoria  input  1  registered play equals ROM word
- endereco_igual_limite  input  1  play counter equals level counter
- ultimo_nivel  input  1  final level reached (difficulty-dependent)
- deu_timeout  input  1  timeout counter reached end
- zera_contador_nivel, zera_contador_jogada, zera_contador_score  output  1 each  synchronous counter clears
- conta_nivel, conta_jogada, conta_score  output  1 each  counter increments
- zeraR, registraR  output  1 each  play register clear / load
- zera_timeout, conta_timeout  output  1 each  timeout counter clear / count
- pronto  output  1  match finished
- ganhou  output  1  finished by clearing ultimo_nivel
- perdeu  output  1  finished by wrong play
- timeout  output  1  finished by timeout
- db_estado  output  4  current state code

Behaviour:
- Outputs are purely decoded from state (Moore). Each output is 0 in every state not listing it.
- State codes and behaviour:
  - inicial 0x0: all outputs 0. iniciar=1 -> preparacao.
  - preparacao 0x1: zera_contador_nivel, zera_contador_jogada, zera_contador_score, zeraR, zera_timeout. Always -> inicio_nivel.
  - inicio_nivel 0x2: zera_contador_jogada, zeraR, zera_timeout. Always -> espera_jogada.
  - espera_jogada 0x3: conta_timeout.
    - fez_jogada=1 -> registra. fez_jogada wins when it coincides with deu_timeout.
    - else deu_timeout=1 and TIMEOUT_ATIVO=1 -> fim_timeout.
    - else stay.
  - registra 0x4: registraR, zera_timeout. Always -> comparacao.
  - comparacao 0x5:
    - jogada_igual_memoria=0 -> fim_errou.
    - else endereco_igual_limite=1 -> ultima_jogada.
    - else -> proxima_jogada.
  - proxima_jogada 0x6: conta_jogada. Always -> espera_jogada.
  - ultima_jogada 0x7: conta_score.
    - ultimo_nivel=1 -> fim_acertou.
    - else -> proximo_nivel.
  - proximo_nivel 0x8: conta_nivel. Always -> inicio_nivel.
  - fim_acertou 0xA: pronto, ganhou.
  - fim_errou 0xE: pronto, perdeu.
  - fim_timeout 0xD: pronto, timeout.
  - In all three end states: iniciar=1 -> preparacao, else hold.
- Unused codes 0x9, 0xB, 0xC, 0xF -> inicial on the next clock; outputs all 0 while in them.
- iniciar is ignored in every state except inicial and the end states. Holding iniciar high in an end state restarts once, then it is ignored until the match ends again.
- Timing:
  - ROM address = play counter. It is stable at least one cycle (espera_jogada) before registra, so the synchronous ROM output is valid in comparacao.
  - The register loads on the edge leaving registra, so comparacao sees the new db_jogada.
  - Minimum per-play latency is 3 cycles from the fez_jogada cycle to the next espera_jogada (registra, comparacao, proxima_jogada).
- Reset:
  - Asynchronous entry to inicial mid-operation; outputs drop to 0 immediately.
  - Datapath counters are not cleared by reset; preparacao does it.
  - Release is synchronous to clock.
- Score counts once per completed level, including the last. The nivel counter does not increment on the final level.

Test Plan:
- Reset while in espera_jogada -> db_estado=0x0 and conta_timeout=0 before the next clock edge. iniciar=1 -> 0x1, 0x2, 0x3 on consecutive edges, with zera_contador_nivel=1 only in 0x1.
- Level 0, correct press (jogada_igual_memoria=1, endereco_igual_limite=1, ultimo_nivel=0) -> states 0x4, 0x5, 0x7, 0x8, 0x2, 0x3. conta_score and conta_nivel each high exactly 1 cycle.
- Level 2, three correct presses -> conta_jogada pulses twice, then 0x7. zera_timeout high in each registra.
- Wrong play (jogada_igual_memoria=0) in comparacao -> 0xE, pronto=1, perdeu=1, ganhou=0. Held until iniciar, then 0x1.
- deu_timeout=1 in espera_jogada:
  - TIMEOUT_ATIVO=1 -> 0xD, timeout=1.
  - TIMEOUT_ATIVO=0 -> stays 0x3.
  - fez_jogada and deu_timeout same cycle -> 0x4.
- Final level correct (ultimo_nivel=1 in 0x7) -> 0xA, ganhou=1, conta_nivel never asserted. Force db_estado to 0xB -> 0x0 next edge.
